// File: rtl/fb_write_scheduler.sv
// Framebuffer write-port scheduler: round-robin burst grants to NREQ drawing
// engines plus a built-in full-screen clear sweep that preempts at burst boundaries.

module fb_ws_lane #(
   parameter int OW  = 2,
   parameter int IDX = 0
) (
   input  logic          req,
   input  logic [OW-1:0] ptr,
   output logic          hi
);
   // requester sits at or above the round-robin pointer
   assign hi = req & (OW'(IDX) >= ptr);
endmodule

module fb_write_scheduler #(
   parameter int NREQ = 4,
   parameter int XW   = 11,
   parameter int YW   = 11,
   parameter int XMAX = 639,
   parameter int YMAX = 479
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      clear_req,
   input  logic [NREQ-1:0]           req,
   input  logic [NREQ-1:0]           req_last,
   input  logic [NREQ-1:0][XW-1:0]   req_x,
   input  logic [NREQ-1:0][YW-1:0]   req_y,
   input  logic [NREQ-1:0]           req_colour,
   output logic [NREQ-1:0]           grant,
   output logic [XW-1:0]             x,
   output logic [YW-1:0]             y,
   output logic                      colour,
   output logic                      pixel_write,
   output logic                      clear_busy,
   output logic                      clear_done
);
   localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {IDLE, SERVE, CLEAR} state_t;

   typedef struct packed {
      logic [XW-1:0] x;
      logic [YW-1:0] y;
      logic          colour;
   } pix_t;

   state_t          state, state_nx;
   logic [OW-1:0]   owner, owner_nx, ptr, ptr_nx, pick;
   logic            pending, pending_nx;
   logic [XW-1:0]   cx, cx_nx;
   logic [YW-1:0]   cy, cy_nx;
   logic            wr, done_nx, accept;
   pix_t            wr_pix;
   logic [NREQ-1:0] hi;

   for (genvar i = 0; i < NREQ; i++) begin : g_lane
      fb_ws_lane #(.OW(OW), .IDX(i)) u_lane (
         .req (req[i]),
         .ptr (ptr),
         .hi  (hi[i])
      );
   end

   // lowest requester at/above the pointer wins; otherwise wrap to the lowest overall
   always_comb begin
      pick = '0;
      for (int i = NREQ - 1; i >= 0; i--) if (req[i]) pick = OW'(i);
      for (int i = NREQ - 1; i >= 0; i--) if (hi[i])  pick = OW'(i);
   end

   always_comb begin
      grant = '0;
      if (state == SERVE) grant[owner] = 1'b1;
   end

   assign accept     = req[owner] & grant[owner];
   assign clear_busy = (state == CLEAR);

   always_comb begin
      state_nx   = state;
      owner_nx   = owner;
      ptr_nx     = ptr;
      pending_nx = pending | clear_req;
      cx_nx      = cx;
      cy_nx      = cy;
      wr         = 1'b0;
      done_nx    = 1'b0;
      wr_pix     = '{x: x, y: y, colour: colour};
      case (state)
         IDLE: begin
            if (pending) begin
               state_nx   = CLEAR;
               pending_nx = 1'b0;
            end else if (|req) begin
               owner_nx = pick;
               state_nx = SERVE;
            end
         end
         SERVE: begin
            if (accept) begin
               wr     = 1'b1;
               wr_pix = '{x: req_x[owner], y: req_y[owner], colour: req_colour[owner]};
               if (req_last[owner]) begin
                  state_nx = IDLE;
                  ptr_nx   = (owner == OW'(NREQ - 1)) ? '0 : owner + OW'(1);
               end
            end
         end
         CLEAR: begin
            pending_nx = pending;
            wr         = 1'b1;
            wr_pix     = '{x: cx, y: cy, colour: 1'b0};
            if (cx == XW'(XMAX)) begin
               cx_nx = '0;
               if (cy == YW'(YMAX)) begin
                  cy_nx    = '0;
                  done_nx  = 1'b1;
                  state_nx = IDLE;
               end else begin
                  cy_nx = cy + YW'(1);
               end
            end else begin
               cx_nx = cx + XW'(1);
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         owner       <= '0;
         ptr         <= '0;
         pending     <= 1'b0;
         cx          <= '0;
         cy          <= '0;
         x           <= '0;
         y           <= '0;
         colour      <= 1'b0;
         pixel_write <= 1'b0;
         clear_done  <= 1'b0;
      end else begin
         state       <= state_nx;
         owner       <= owner_nx;
         ptr         <= ptr_nx;
         pending     <= pending_nx;
         cx          <= cx_nx;
         cy          <= cy_nx;
         pixel_write <= wr;
         clear_done  <= done_nx;
         if (wr) begin
            x      <= wr_pix.x;
            y      <= wr_pix.y;
            colour <= wr_pix.colour;
         end
      end
   end
endmodule
